// File: rtl/divremsqrt_prenorm.sv
// divremsqrt_prenorm: mantissa pre-normalizer for the divide/remainder/sqrt
// datapath. Accepts a raw mantissa and biased exponent, shifts the mantissa
// left by up to STEP bits per cycle until the leading one sits at bit NF,
// and reports the adjusted two's-complement exponent (DivUe source).
//
// Optional feature macro: DIVREMSQRT_PRENORM_BYPASS_EN
//   defined   -> a normal (leading bit set) nonzero input skips SHIFT
//   undefined -> every nonzero input passes through at least one SHIFT cycle
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high (InValid/InReady on the input side, OutValid/OutReady on
// the output side). Once OutValid rises, Mnorm/Ue/ZeroOut hold steady until
// the transfer; valid never drops without a transfer except on Flush/reset.
module divremsqrt_prenorm #(
    parameter int NF   = 52,
    parameter int NE   = 11,
    parameter int STEP = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Flush,
    input  logic          InValid,
    output logic          InReady,
    input  logic [NF:0]   Xm,
    input  logic [NE-1:0] Xe,
    input  logic          XSubnorm,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [NF:0]   Mnorm,
    output logic [NE+1:0] Ue,
    output logic          ZeroOut,
    output logic [1:0]    dbg_state
);

    localparam int KW = $clog2(STEP + 1);
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NF:0]     mreg;
    logic [NE+1:0]   ereg;
    logic            zero_flag;
    logic [KW-1:0]   k;
    logic            found;
    logic            accept;
    logic            xm_zero;

    assign accept  = (state == IDLE) && InValid && !Flush;
    assign xm_zero = (Xm == '0);

    // Leading-zero count of the top STEP bits of the working mantissa,
    // saturated at STEP (all STEP bits zero means "shift a full step").
    always_comb begin
        k     = STEP_K;
        found = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (!found && mreg[NF-i]) begin
                k     = KW'(i);
                found = 1'b1;
            end
        end
    end

    // Next-state selection; Flush overrides everything including the handshakes.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (InValid) begin
                    if (xm_zero) begin
                        state_next = DONE;
                    end else begin
`ifdef DIVREMSQRT_PRENORM_BYPASS_EN
                        state_next = Xm[NF] ? DONE : SHIFT;
`else
                        state_next = SHIFT;
`endif
                    end
                end
            end
            SHIFT: begin
                if (k != STEP_K) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (Flush) begin
            state_next = IDLE;
        end
    end

    // State register; reset drops straight to IDLE without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: load on accept, then shift mantissa / decrement exponent per SHIFT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mreg      <= '0;
            ereg      <= '0;
            zero_flag <= 1'b0;
        end else if (accept) begin
            mreg      <= Xm;
            zero_flag <= xm_zero;
            if (xm_zero) begin
                ereg <= '0;
            end else if (XSubnorm) begin
                ereg <= (NE+2)'(1);
            end else begin
                ereg <= {2'b00, Xe};
            end
        end else if (state == SHIFT && !Flush) begin
            mreg <= mreg << k;
            ereg <= ereg - {{(NE+2-KW){1'b0}}, k};
        end
    end

    assign InReady   = (state == IDLE);
    assign OutValid  = (state == DONE);
    assign Mnorm     = mreg;
    assign Ue        = ereg;
    assign ZeroOut   = zero_flag;
    assign dbg_state = state;

endmodule

// File: tb/tb_divremsqrt_prenorm.sv
// Testbench for divremsqrt_prenorm (NF=52, NE=11, STEP=4).
// Directed steps in one initial block; expected results come from a
// behavioral normalize model and are queued at drive time, popped at output.
module tb_divremsqrt_prenorm;

    localparam int NF   = 52;
    localparam int NE   = 11;
    localparam int STEP = 4;
    localparam int W    = 1 + (NE + 2) + (NF + 1);

    logic          clk;
    logic          reset;
    logic          Flush;
    logic          InValid;
    logic          InReady;
    logic [NF:0]   Xm;
    logic [NE-1:0] Xe;
    logic          XSubnorm;
    logic          OutValid;
    logic          OutReady;
    logic [NF:0]   Mnorm;
    logic [NE+1:0] Ue;
    logic          ZeroOut;
    logic [1:0]    dbg_state;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           checks;
    int           failures;

`ifdef DIVREMSQRT_PRENORM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    divremsqrt_prenorm #(.NF(NF), .NE(NE), .STEP(STEP)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .Xm(Xm), .Xe(Xe), .XSubnorm(XSubnorm),
        .OutValid(OutValid), .OutReady(OutReady),
        .Mnorm(Mnorm), .Ue(Ue), .ZeroOut(ZeroOut),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: full normalize in one step, plus expected latency.
    task automatic push_expect(input logic [NF:0] xm, input logic [NE-1:0] xe, input logic sub);
        int            lz;
        logic [NF:0]   m;
        logic [NE+1:0] e;
        int            lat;
        if (xm == '0) begin
            exp_q.push_back({1'b1, {(NE+2){1'b0}}, {(NF+1){1'b0}}});
            lat_q.push_back(1);
        end else begin
            lz = 0;
            while (xm[NF-lz] == 1'b0) lz++;
            m = xm << lz;
            e = sub ? (NE+2)'(1) : {2'b00, xe};
            e = e - (NE+2)'(lz);
            lat = (BYPASS && lz == 0) ? 1 : 2 + lz / STEP;
            exp_q.push_back({1'b0, e, m});
            lat_q.push_back(lat);
        end
    endtask

    task automatic drive_accept(input logic [NF:0] xm, input logic [NE-1:0] xe, input logic sub);
        check("in_ready_before_accept", W'(InReady), W'(1));
        InValid  = 1'b1;
        Xm       = xm;
        Xe       = xe;
        XSubnorm = sub;
        tick();
        InValid  = 1'b0;
    endtask

    // Waits (bounded) for OutValid, compares latency and result, optionally stalls.
    task automatic collect(input string tag, input int stall);
        int           lat;
        logic [W-1:0] expv;
        int           exp_lat;
        logic [W-1:0] held;
        lat = 1;
        while (OutValid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        expv    = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        check({tag, "_latency"}, W'(lat), W'(exp_lat));
        check({tag, "_result"}, {ZeroOut, Ue, Mnorm}, expv);
        held = {ZeroOut, Ue, Mnorm};
        for (int i = 0; i < stall; i++) begin
            InValid  = 1'b1;
            OutReady = 1'b0;
            tick();
            check({tag, "_stall_hold"}, {ZeroOut, Ue, Mnorm}, held);
            check({tag, "_stall_valid"}, W'({OutValid, InReady}), W'(2'b10));
        end
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        InValid  = 1'b0;
        check({tag, "_back_to_idle"}, W'({OutValid, InReady}), W'(2'b01));
    endtask

    task automatic run_op(input string tag, input logic [NF:0] xm, input logic [NE-1:0] xe, input logic sub);
        push_expect(xm, xe, sub);
        drive_accept(xm, xe, sub);
        collect(tag, 0);
    endtask

    initial begin
        logic [63:0]   r;
        logic [NF:0]   xm;
        logic [NF:0]   mask;
        int            lz;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        Flush    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        Xm       = '0;
        Xe       = '0;
        XSubnorm = 1'b0;
        #12;
        check("reset_outputs", W'({OutValid, InReady, ZeroOut}), W'(3'b010));
        check("reset_mnorm", W'(Mnorm), W'(0));
        check("reset_ue", W'(Ue), W'(0));
        @(negedge clk);
        reset = 1'b0;
        #4;

        // Fixed constant checks for the documented operands.
        push_expect(53'h18000000000000, 11'h3FF, 1'b0);
        drive_accept(53'h18000000000000, 11'h3FF, 1'b0);
        collect("normal", 0);
        push_expect(53'h00800000000000, 11'h000, 1'b1);
        drive_accept(53'h00800000000000, 11'h000, 1'b1);
        begin
            int lat;
            lat = 1;
            while (OutValid !== 1'b1 && lat < 100) begin tick(); lat++; end
            check("sub_lz5_const", {ZeroOut, Ue, Mnorm}, {1'b0, 13'h1FFC, 53'h10000000000000});
            check("sub_lz5_latency", W'(lat), W'(3));
            OutReady = 1'b1; tick(); OutReady = 1'b0;
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
        push_expect(53'h1, 11'h000, 1'b1);
        drive_accept(53'h1, 11'h000, 1'b1);
        begin
            int lat;
            lat = 1;
            while (OutValid !== 1'b1 && lat < 100) begin tick(); lat++; end
            check("sub_lz52_const", {ZeroOut, Ue, Mnorm}, {1'b0, 13'h1FCD, 53'h10000000000000});
            check("sub_lz52_latency", W'(lat), W'(15));
            OutReady = 1'b1; tick(); OutReady = 1'b0;
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
        run_op("zero", 53'h0, 11'h000, 1'b1);
        check("zero_const_after", W'(Ue), W'(0));

        // Stall in DONE with InValid high; next operand accepted one cycle after release.
        push_expect(53'h00000123456789, 11'h000, 1'b1);
        drive_accept(53'h00000123456789, 11'h000, 1'b1);
        collect("stall", 3);
        run_op("after_stall", 53'h1ABCDEF0123456, 11'h400, 1'b0);

        // Flush in IDLE beats accept.
        InValid = 1'b1; Xm = 53'h1F; XSubnorm = 1'b1; Flush = 1'b1;
        tick();
        InValid = 1'b0; Flush = 1'b0;
        tick();
        check("flush_beats_accept", W'({OutValid, InReady}), W'(2'b01));

        // Asynchronous reset in the third SHIFT cycle of Xm=1.
        drive_accept(53'h1, 11'h000, 1'b1);
        tick();
        tick();
        check("third_shift_state", W'(dbg_state), W'(1));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mid_shift", W'({OutValid, InReady}), W'(2'b01));
        @(negedge clk);
        reset = 1'b0;
        #4;

        // Flush in the third SHIFT cycle: IDLE on the next edge, no OutValid pulse.
        drive_accept(53'h1, 11'h000, 1'b1);
        tick();
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("flush_mid_shift", W'({OutValid, InReady}), W'(2'b01));
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (OutValid === 1'b1) seen++;
            end
            check("flush_no_outvalid", W'(seen), W'(0));
        end

        // Random operands across the leading-zero range.
        for (int n = 0; n < 12; n++) begin
            lz   = $urandom_range(0, NF);
            r    = {$urandom, $urandom};
            mask = (53'h1 << (NF - lz)) - 53'h1;
            xm   = (53'h1 << (NF - lz)) | (r[NF:0] & mask);
            if (lz == 0) begin
                run_op("rand_normal", xm, NE'($urandom_range(1, 2046)), 1'b0);
            end else begin
                run_op("rand_sub", xm, 11'h000, 1'b1);
            end
        end

        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divremsqrt_prenorm.md
DIVREMSQRT_PRENORM -- requirements
Module: divremsqrt_prenorm

Interface
REQ-001: Parameter NF, default 52, mantissa fraction width; Xm/Mnorm are NF+1 bits with the leading bit at [NF].
REQ-002: Parameter NE, default 11, stored exponent width.
REQ-003: Parameter STEP, default 4, maximum left-shift distance per SHIFT cycle; legal range 1..NF.
REQ-004: clk  input  1  single clock, rising edge.
REQ-005: reset  input  1  asynchronous, active-high.
REQ-006: Flush  input  1  synchronous abort to IDLE.
REQ-007: InValid  input  1  operand valid; InReady  output  1  operand accepted when both are high.
REQ-008: Xm  input  NF+1  raw mantissa; the leading bit is 0 for subnormal inputs.
REQ-009: Xe  input  NE  biased exponent; XSubnorm  input  1  input is subnormal.
REQ-010: OutValid  output  1  result valid; OutReady  input  1  result consumed when both are high.
REQ-011: Mnorm  output  NF+1  normalized mantissa, Mnorm[NF]=1 unless ZeroOut.
REQ-012: Ue  output  NE+2  two's-complement biased exponent of Mnorm; this is the divider's DivUe source.
REQ-013: ZeroOut  output  1  input mantissa was all zero.

Function
REQ-014: FSM states are IDLE, SHIFT and DONE; InReady=1 only in IDLE; OutValid=1 only in DONE.
REQ-015: On accept in IDLE, the block shall register Xm into Mreg and set Ereg={2'b00,Xe} if ~XSubnorm, else Ereg=1.
REQ-016: On accept with Xm==0, the block shall set ZeroOut, set Ereg=0 and go to DONE without entering SHIFT.
REQ-017: On accept with Xm!=0, next state is DONE if Xm[NF]=1 and DIVREMSQRT_PRENORM_BYPASS_EN is defined; otherwise next state is SHIFT.
REQ-018: Each SHIFT cycle, k = leading-zero count of Mreg[NF:NF-STEP+1] saturated at STEP; Mreg <= Mreg<<k (zero fill); Ereg <= Ereg-k.
REQ-019: SHIFT goes to DONE when k<STEP and stays in SHIFT when k==STEP; the SHIFT cycle count is floor(lz/STEP)+1.
REQ-020: Ereg arithmetic is NE+2-bit two's complement, wrap-free for all legal inputs; the minimum value is 1-NF.
REQ-021: In DONE, Mnorm, Ue and ZeroOut shall equal Mreg, Ereg and the zero flag, held stable until OutReady=1; the next state is then IDLE.
REQ-022: In DONE, InValid shall be ignored even when OutReady=1 in the same cycle; no back-to-back accept occurs in that cycle.
REQ-023: Flush=1 forces IDLE next cycle from any state and discards the operand; Flush takes priority over accept and over the output handshake.
REQ-024: Latency from accept to OutValid is 1 cycle for a zero input, 1 cycle for a normal input with bypass, and 1+floor(lz/STEP)+1 cycles otherwise.
REQ-025: Outputs are registered; no combinational path exists from InValid/Xm to any output, or from OutReady to any output other than through state.

Reset
REQ-026: Assertion of reset shall immediately force IDLE, asynchronously and including mid-SHIFT.
REQ-027: Reset values are OutValid=0, InReady=1, Mnorm=0, Ue=0 and ZeroOut=0.
REQ-028: After reset deassertion, an operand is acceptable on the first clk edge.

Configuration
REQ-029: Macro DIVREMSQRT_PRENORM_BYPASS_EN defined: a normal nonzero input skips SHIFT and reaches DONE one cycle after accept.
REQ-030: Macro absent: every nonzero input passes through at least one SHIFT cycle, so a normal input gets k=0 and reaches DONE two cycles after accept; results are bit-identical either way.

Verification (NF=52, NE=11, STEP=4, Ue 13 bits)
REQ-031: Normal input, Xe=0x3FF, Xm=0x18000000000000, bypass on -> OutValid 1 cycle after accept, Mnorm=0x18000000000000, Ue=0x03FF; with bypass off -> 2 cycles, same values.
REQ-032: Subnormal input, Xm=0x00800000000000 (lz=5) -> 2 SHIFT cycles, Mnorm=0x10000000000000, Ue=0x1FFC (-4).
REQ-033: Subnormal input, Xm=0x1 (lz=52) -> 14 SHIFT cycles, Mnorm=0x10000000000000, Ue=0x1FCD (-51).
REQ-034: Xm=0 with XSubnorm=1 -> OutValid 1 cycle after accept, ZeroOut=1, Ue=0, Mnorm=0.
REQ-035: OutReady held low 3 cycles in DONE while InValid=1 -> outputs stable and InReady=0; then OutReady=1 -> IDLE, and the next operand is accepted one cycle later.
REQ-036: Reset asserted in the 3rd SHIFT cycle of Xm=0x1 -> OutValid=0 and InReady=1 immediately, without waiting for a clk edge; Flush in that cycle instead -> IDLE on the next edge, no OutValid pulse.
